// File: rtl/pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_meter
// Description : Measures the period and high time of an external PWM
//               waveform in clk cycles, reported once per rising edge.
//               Reports loss of signal when no edge arrives within TIMEOUT
//               cycles, together with the level the pin is stuck at.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 54000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             signal_lost,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_high_lat;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_meas_valid;
  logic             r_signal_lost;
  logic             r_stuck_level;

  logic             r_sync1;
  logic             r_pwm_s;
  logic             r_pwm_d;

  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;

  // Two-flop synchronizer plus edge-delay flop; reset high so a pin that is
  // already high when reset releases does not look like a rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_pwm_s <= 1'b1;
      r_pwm_d <= 1'b1;
    end else begin
      r_sync1 <= pwm_in;
      r_pwm_s <= r_sync1;
      r_pwm_d <= r_pwm_s;
    end
  end

  assign w_rise    = r_pwm_s & ~r_pwm_d;
  assign w_fall    = ~r_pwm_s & r_pwm_d;
  // Compare with >= so a fall landing exactly on TIMEOUT in HIGH (which moves
  // the count one past TIMEOUT) still times out on the following cycle.
  assign w_timeout = (r_count >= C_TIMEOUT);

  // Measurement FSM: counts rise-to-fall and rise-to-rise intervals and
  // drives all registered outputs. An edge always takes priority over timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_high_lat    <= '0;
      r_period      <= '0;
      r_high        <= '0;
      r_meas_valid  <= 1'b0;
      r_signal_lost <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Only a rise arms the measurement; the first period is not reported.
          if (w_rise) begin
            r_state <= ST_HIGH;
            r_count <= C_ONE;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_state    <= ST_LOW;
            r_high_lat <= r_count;
            r_count    <= r_count + C_ONE;
          end else if (w_timeout) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_signal_lost <= 1'b1;
            r_stuck_level <= r_pwm_s;
          end else begin
            r_count <= r_count + C_ONE;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_state       <= ST_HIGH;
            r_period      <= r_count;
            r_high        <= r_high_lat;
            r_meas_valid  <= 1'b1;
            r_signal_lost <= 1'b0;
            r_count       <= C_ONE;
          end else if (w_timeout) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_signal_lost <= 1'b1;
            r_stuck_level <= r_pwm_s;
          end else begin
            r_count <= r_count + C_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign period_out  = r_period;
  assign high_out    = r_high;
  assign meas_valid  = r_meas_valid;
  assign signal_lost = r_signal_lost;
  assign stuck_level = r_stuck_level;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_meter
// Description : Self-checking bench for pwm_duty_meter. TIMEOUT is scaled
//               down to keep run time short; waveform periods scale with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 540;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b1;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             signal_lost;
  logic             stuck_level;

  int checks   = 0;
  int errors   = 0;
  int meas_cnt = 0;

  typedef struct {
    int period;
    int high;
    int n;
    int exp_meas;
    int exp_period;
    int exp_high;
    int exp_lost;
  } vec_t;

  vec_t vecs [6];

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .signal_lost(signal_lost),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every measurement pulse must come with signal_lost already cleared.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      meas_cnt++;
      check("lost_clear_with_valid", 32'(signal_lost), 32'd0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pwm_cycles(input int period, input int high, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      wait_cyc(high);
      pwm_in = 1'b0;
      wait_cyc(period - high);
    end
  endtask

  // Called at posedge+2; 'elapsed' posedges have passed since the pin rose.
  // Lost must appear exactly TMO cycles after the synchronized rise.
  task automatic check_timeout(input string tag, input int elapsed,
                               input int lost_before, input int stuck_before,
                               input int stuck_after);
    repeat (TMO + 2 - elapsed) @(posedge clk);
    @(negedge clk);
    check({tag, "_lost_early"},  32'(signal_lost), 32'(lost_before));
    check({tag, "_stuck_early"}, 32'(stuck_level), 32'(stuck_before));
    @(negedge clk);
    check({tag, "_lost"},  32'(signal_lost), 32'd1);
    check({tag, "_stuck"}, 32'(stuck_level), 32'(stuck_after));
    @(posedge clk);
    #2;
  endtask

  task automatic apply_vec(input int i);
    int base;
    base = meas_cnt;
    pwm_cycles(vecs[i].period, vecs[i].high, vecs[i].n);
    check($sformatf("row%0d_meas", i),   meas_cnt - base,    vecs[i].exp_meas);
    check($sformatf("row%0d_period", i), 32'(period_out),   vecs[i].exp_period);
    check($sformatf("row%0d_high", i),   32'(high_out),     vecs[i].exp_high);
    check($sformatf("row%0d_lost", i),   32'(signal_lost),  vecs[i].exp_lost);
  endtask

  initial begin
    int base;
    vecs[0] = '{270,  70, 3, 2, 270,  70, 0};  // fresh start: first rise only arms
    vecs[1] = '{270, 135, 1, 0, 270,  70, 1};  // after timeout: one rise, nothing reported
    vecs[2] = '{270, 135, 2, 2, 270, 135, 0};  // resumes: lost clears with first report
    vecs[3] = '{540,  10, 3, 3, 540,  10, 0};  // period equal to TIMEOUT: edge wins
    vecs[4] = '{541,  20, 3, 1, 540,  10, 1};  // one past TIMEOUT: times out each period
    vecs[5] = '{300, 150, 3, 2, 300, 150, 0};  // recovery from IDLE

    // Reset with pin held high
    rst    = 1'b0;
    pwm_in = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("rst_period", 32'(period_out),  32'd0);
    check("rst_valid",  32'(meas_valid),  32'd0);
    rst = 1'b1;
    wait_cyc(100);
    check("idle_meas",   meas_cnt,          32'd0);
    check("idle_period", 32'(period_out),  32'd0);
    check("idle_high",   32'(high_out),    32'd0);
    check("idle_lost",   32'(signal_lost), 32'd0);
    check("idle_stuck",  32'(stuck_level), 32'd0);
    pwm_in = 1'b0;
    wait_cyc(20);
    check("idle_fall_meas", meas_cnt, 32'd0);

    apply_vec(0);

    // Stuck high after a rise that closes the last measured period
    base   = meas_cnt;
    pwm_in = 1'b1;
    check_timeout("hi", 0, 0, 0, 1);
    check("hi_meas",   meas_cnt - base,   32'd1);
    check("hi_period", 32'(period_out),  32'd270);
    check("hi_high",   32'(high_out),    32'd70);

    // Stuck low: one pulse, then the pin stays low
    pwm_in = 1'b0;
    wait_cyc(30);
    check("lo_idle_stuck", 32'(stuck_level), 32'd1);
    base   = meas_cnt;
    pwm_in = 1'b1;
    wait_cyc(70);
    pwm_in = 1'b0;
    check_timeout("lo", 70, 1, 1, 0);
    check("lo_meas",   meas_cnt - base,  32'd0);
    check("lo_period", 32'(period_out), 32'd270);

    for (int i = 1; i < 6; i++) apply_vec(i);

    // Reset in the middle of a high phase
    base   = meas_cnt;
    pwm_in = 1'b1;
    wait_cyc(50);
    rst = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    check("mid_rst_period", 32'(period_out),  32'd0);
    check("mid_rst_high",   32'(high_out),    32'd0);
    check("mid_rst_lost",   32'(signal_lost), 32'd0);
    check("mid_rst_meas",   meas_cnt - base,  32'd1);
    wait_cyc(99);
    pwm_in = 1'b0;
    wait_cyc(150);
    check("post_rst_quiet", meas_cnt - base,  32'd1);
    pwm_cycles(300, 100, 2);
    check("post_rst_meas",   meas_cnt - base,  32'd2);
    check("post_rst_period", 32'(period_out), 32'd300);
    check("post_rst_high",   32'(high_out),   32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
